writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/ucrv32_pkg.sv | 59 +++++
 rtl/wb_skid_buffer.sv | 57 +++++
 rtl/writeback_stage.sv | 97 +++++++++
 tb/tb_writeback_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ucrv32_pkg.sv
// Shared RV32 core types: word type, writeback source select, load funct3 codes and the writeback entry.
// Also provides the load-extraction helper that is used on the writeback path.
package ucrv32_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_CSR  = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0] rd_addr;
        logic       rd_we;
        wb_sel_e    wb_sel;
        word_t      alu_result;
        word_t      pc;
        word_t      load_data;
        word_t      csr_data;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } wb_entry_t;

    typedef struct packed {
        word_t data;
        logic  err;
    } load_res_t;

    // Unknown funct3 codes and misaligned halves/words flag err; data is then don't-care.
    function automatic load_res_t load_extract(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo,
                                               input word_t      raw);
        load_res_t   res;
        logic [7:0]  b;
        logic [15:0] h;
        b        = raw[{addr_lo, 3'b000} +: 8];
        h        = addr_lo[1] ? raw[31:16] : raw[15:0];
        res.data = '0;
        res.err  = 1'b0;
        case (funct3)
            F3_LB:   res.data = {{24{b[7]}}, b};
            F3_LH:   begin res.data = {{16{h[15]}}, h}; res.err = addr_lo[0]; end
            F3_LW:   begin res.data = raw; res.err = (addr_lo != 2'b00); end
            F3_LBU:  res.data = {24'b0, b};
            F3_LHU:  begin res.data = {16'b0, h}; res.err = addr_lo[0]; end
            default: res.err = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// Two-entry in-order FIFO with a registered ready (high while fewer than two entries are held).
// Latency: one edge from push to head; pop and push may share an edge, ready drops only when full.
module wb_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_pop,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic [1:0]   count_nxt;
    logic         push;
    logic         pop;

    assign push      = in_valid && in_ready;
    assign pop       = out_pop && (count != 2'd0);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 2'd1;
        end else if (pop && !push) begin
            count_nxt = count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            count    <= count_nxt;
            in_ready <= (count_nxt != 2'd2);
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: buffers memory-stage results, forms the register write and counts retirements.
// Latency: accept at edge N, write port valid after edge N+1; stall_i freezes retire, input accepted until full.
module writeback_stage
    import ucrv32_pkg::*;
#(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk_i,
    input  logic                 n_rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [4:0]           in_rd_addr_i,
    input  logic                 in_rd_we_i,
    input  logic [1:0]           in_wb_sel_i,
    input  logic [31:0]          in_alu_result_i,
    input  logic [31:0]          in_pc_i,
    input  logic [31:0]          in_load_data_i,
    input  logic [31:0]          in_csr_data_i,
    input  logic [2:0]           in_funct3_i,
    input  logic [1:0]           in_addr_lo_i,
    input  logic                 stall_i,
    output logic [4:0]           rd_addr_o,
    output logic [31:0]          wd_o,
    output logic                 we_o,
    output logic                 err_o,
    output logic [INSTRET_W-1:0] instret_o
);

    wb_entry_t in_entry;
    wb_entry_t head;
    logic      head_vld;
    logic      retire;
    load_res_t ld;
    word_t     wd_nxt;
    logic      err_nxt;
    logic      we_nxt;

    always_comb begin
        in_entry.rd_addr    = in_rd_addr_i;
        in_entry.rd_we      = in_rd_we_i;
        in_entry.wb_sel     = wb_sel_e'(in_wb_sel_i);
        in_entry.alu_result = in_alu_result_i;
        in_entry.pc         = in_pc_i;
        in_entry.load_data  = in_load_data_i;
        in_entry.csr_data   = in_csr_data_i;
        in_entry.funct3     = in_funct3_i;
        in_entry.addr_lo    = in_addr_lo_i;
    end

    wb_skid_buffer #(.W($bits(wb_entry_t))) u_fifo (
        .clk       (clk_i),
        .n_rst     (n_rst),
        .in_valid  (in_valid_i),
        .in_ready  (in_ready_o),
        .in_data   (in_entry),
        .out_valid (head_vld),
        .out_pop   (retire),
        .out_data  (head)
    );

    assign retire = head_vld && !stall_i;

    always_comb begin
        ld      = load_extract(head.funct3, head.addr_lo, head.load_data);
        wd_nxt  = head.alu_result;
        err_nxt = 1'b0;
        case (head.wb_sel)
            WB_ALU:  wd_nxt = head.alu_result;
            WB_LOAD: begin wd_nxt = ld.data; err_nxt = ld.err; end
            WB_PC4:  wd_nxt = head.pc + 32'd4;
            WB_CSR:  wd_nxt = head.csr_data;
            default: wd_nxt = head.alu_result;
        endcase
        // x0 writes and faulting loads still retire, they just never reach the register file.
        we_nxt = head.rd_we && (head.rd_addr != 5'd0) && !err_nxt;
    end

    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            rd_addr_o <= 5'd0;
            wd_o      <= 32'd0;
            we_o      <= 1'b0;
            err_o     <= 1'b0;
            instret_o <= '0;
        end else if (retire) begin
            rd_addr_o <= head.rd_addr;
            wd_o      <= wd_nxt;
            we_o      <= we_nxt;
            err_o     <= err_nxt;
            instret_o <= instret_o + 1'b1;
        end else begin
            we_o      <= 1'b0;
            err_o     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: single retires over every source/load type, stall fill/drain, reset mid-stall.
module tb_writeback_stage;

    logic        clk_i = 1'b0;
    logic        n_rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [4:0]  in_rd_addr_i;
    logic        in_rd_we_i;
    logic [1:0]  in_wb_sel_i;
    logic [31:0] in_alu_result_i;
    logic [31:0] in_pc_i;
    logic [31:0] in_load_data_i;
    logic [31:0] in_csr_data_i;
    logic [2:0]  in_funct3_i;
    logic [1:0]  in_addr_lo_i;
    logic        stall_i;
    logic [4:0]  rd_addr_o;
    logic [31:0] wd_o;
    logic        we_o;
    logic        err_o;
    logic [3:0]  instret_o;

    writeback_stage #(.INSTRET_W(4)) dut (
        .clk_i           (clk_i),
        .n_rst           (n_rst),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_rd_addr_i    (in_rd_addr_i),
        .in_rd_we_i      (in_rd_we_i),
        .in_wb_sel_i     (in_wb_sel_i),
        .in_alu_result_i (in_alu_result_i),
        .in_pc_i         (in_pc_i),
        .in_load_data_i  (in_load_data_i),
        .in_csr_data_i   (in_csr_data_i),
        .in_funct3_i     (in_funct3_i),
        .in_addr_lo_i    (in_addr_lo_i),
        .stall_i         (stall_i),
        .rd_addr_o       (rd_addr_o),
        .wd_o            (wd_o),
        .we_o            (we_o),
        .err_o           (err_o),
        .instret_o       (instret_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [4:0]  rd;
        logic        rwe;
        logic [31:0] src;
        logic        exp_we;
        logic [31:0] exp_wd;
        logic        exp_err;
    } vec_t;

    vec_t       vecs [16];
    int         n_vec = 0;
    int         n_bad = 0;
    logic       acc;
    logic [3:0] exp_instret = 4'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        acc = in_valid_i && in_ready_o;
        @(posedge clk_i);
        #1;
    endtask

    // Non-selected sources carry distinct junk so a wrong mux choice shows up.
    task automatic drive(input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] alo,
                         input logic [4:0] rd, input logic rwe, input logic [31:0] src);
        in_wb_sel_i     = sel;
        in_funct3_i     = f3;
        in_addr_lo_i    = alo;
        in_rd_addr_i    = rd;
        in_rd_we_i      = rwe;
        in_alu_result_i = (sel == 2'd0) ? src : 32'hA5A5_A5A5;
        in_load_data_i  = (sel == 2'd1) ? src : 32'h5A5A_5A5A;
        in_pc_i         = (sel == 2'd2) ? src : 32'h0000_1000;
        in_csr_data_i   = (sel == 2'd3) ? src : 32'h3C3C_3C3C;
    endtask

    task automatic setv(input int i, input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] alo,
                        input logic [4:0] rd, input logic rwe, input logic [31:0] src,
                        input logic ew, input logic [31:0] ewd, input logic ee);
        vecs[i] = '{sel, f3, alo, rd, rwe, src, ew, ewd, ee};
    endtask

    task automatic run_vec(input int i);
        drive(vecs[i].sel, vecs[i].f3, vecs[i].alo, vecs[i].rd, vecs[i].rwe, vecs[i].src);
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        exp_instret = exp_instret + 4'd1;
        chk($sformatf("v%0d_we", i), we_o, vecs[i].exp_we);
        chk($sformatf("v%0d_err", i), err_o, vecs[i].exp_err);
        chk($sformatf("v%0d_instret", i), instret_o, exp_instret);
        if (vecs[i].exp_we) begin
            chk($sformatf("v%0d_rd", i), rd_addr_o, vecs[i].rd);
            chk($sformatf("v%0d_wd", i), wd_o, vecs[i].exp_wd);
        end
        tick();
        chk($sformatf("v%0d_we_pulse", i), we_o, 1'b0);
        chk($sformatf("v%0d_err_pulse", i), err_o, 1'b0);
    endtask

    logic [4:0]  st_rd [3];
    logic [31:0] st_wd [3];
    int          k;
    int          nw;
    int          first_cyc;
    int          last_cyc;
    logic        saw_we;

    initial begin
        //   idx sel   f3      alo   rd     rwe   src            we    wd             err
        setv(0,  2'd1, 3'b000, 2'd2, 5'd5,  1'b1, 32'h0080_FF00, 1'b1, 32'hFFFF_FF80, 1'b0);
        setv(1,  2'd1, 3'b101, 2'd2, 5'd7,  1'b1, 32'h8001_0000, 1'b1, 32'h0000_8001, 1'b0);
        setv(2,  2'd1, 3'b010, 2'd1, 5'd8,  1'b1, 32'h1122_3344, 1'b0, 32'h0,         1'b1);
        setv(3,  2'd0, 3'b000, 2'd0, 5'd0,  1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0);
        setv(4,  2'd0, 3'b000, 2'd0, 5'd3,  1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0);
        setv(5,  2'd3, 3'b000, 2'd0, 5'd9,  1'b1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0);
        setv(6,  2'd2, 3'b000, 2'd0, 5'd1,  1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 1'b0);
        setv(7,  2'd1, 3'b001, 2'd2, 5'd10, 1'b1, 32'h9ABC_1234, 1'b1, 32'hFFFF_9ABC, 1'b0);
        setv(8,  2'd1, 3'b000, 2'd1, 5'd11, 1'b1, 32'h0000_7F00, 1'b1, 32'h0000_007F, 1'b0);
        setv(9,  2'd1, 3'b100, 2'd3, 5'd12, 1'b1, 32'hF100_0000, 1'b1, 32'h0000_00F1, 1'b0);
        setv(10, 2'd1, 3'b011, 2'd0, 5'd13, 1'b1, 32'h1234_5678, 1'b0, 32'h0,         1'b1);
        setv(11, 2'd1, 3'b001, 2'd3, 5'd14, 1'b1, 32'h1234_5678, 1'b0, 32'h0,         1'b1);
        setv(12, 2'd0, 3'b000, 2'd0, 5'd4,  1'b0, 32'h5555_5555, 1'b0, 32'h0,         1'b0);
        setv(13, 2'd1, 3'b010, 2'd0, 5'd15, 1'b1, 32'h8765_4321, 1'b1, 32'h8765_4321, 1'b0);
        setv(14, 2'd2, 3'b000, 2'd0, 5'd2,  1'b1, 32'h0000_1000, 1'b1, 32'h0000_1004, 1'b0);
        setv(15, 2'd1, 3'b000, 2'd0, 5'd16, 1'b1, 32'h0000_00FE, 1'b1, 32'hFFFF_FFFE, 1'b0);

        n_rst      = 1'b0;
        in_valid_i = 1'b0;
        stall_i    = 1'b0;
        drive(2'd0, 3'b000, 2'd0, 5'd0, 1'b0, 32'h0);
        tick();
        tick();
        chk("rst_we", we_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_rd", rd_addr_o, 5'd0);
        chk("rst_wd", wd_o, 32'd0);
        chk("rst_ready", in_ready_o, 1'b0);
        chk("rst_instret", instret_o, 4'd0);
        n_rst = 1'b1;
        tick();
        chk("ready_after_rst", in_ready_o, 1'b1);

        // Sixteen retires on a 4-bit counter: the last one wraps it to zero.
        for (int i = 0; i < 16; i++) run_vec(i);
        chk("instret_wrap", instret_o, 4'd0);

        // Stall: fill the FIFO with three offered entries, only two fit.
        st_rd[0] = 5'd20; st_wd[0] = 32'h0000_0100;
        st_rd[1] = 5'd21; st_wd[1] = 32'h0000_0200;
        st_rd[2] = 5'd22; st_wd[2] = 32'h0000_0300;
        stall_i = 1'b1;
        saw_we  = 1'b0;
        k = 0;
        drive(2'd0, 3'b000, 2'd0, st_rd[0], 1'b1, st_wd[0]);
        in_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (we_o) saw_we = 1'b1;
            if (acc) begin
                k++;
                if (k < 3) drive(2'd0, 3'b000, 2'd0, st_rd[k], 1'b1, st_wd[k]);
                else in_valid_i = 1'b0;
            end
        end
        chk("stall_accepts", k, 2);
        chk("stall_ready_low", in_ready_o, 1'b0);
        chk("stall_no_we", saw_we, 1'b0);

        stall_i   = 1'b0;
        nw        = 0;
        first_cyc = -1;
        last_cyc  = -1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (acc) begin
                k++;
                in_valid_i = 1'b0;
            end
            if (we_o) begin
                if (nw < 3) begin
                    chk($sformatf("drain%0d_rd", nw), rd_addr_o, st_rd[nw]);
                    chk($sformatf("drain%0d_wd", nw), wd_o, st_wd[nw]);
                end
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                nw++;
            end
        end
        chk("drain_count", nw, 3);
        chk("drain_span", last_cyc - first_cyc, 2);
        chk("drain_accepts", k, 3);
        chk("drain_instret", instret_o, 4'd3);

        // Reset while stalled with a full FIFO: nothing may ever be written.
        stall_i = 1'b1;
        drive(2'd0, 3'b000, 2'd0, 5'd25, 1'b1, 32'h0000_0AAA);
        in_valid_i = 1'b1;
        tick();
        tick();
        in_valid_i = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        chk("midrst_we", we_o, 1'b0);
        chk("midrst_ready", in_ready_o, 1'b0);
        chk("midrst_instret", instret_o, 4'd0);
        chk("midrst_wd", wd_o, 32'd0);
        stall_i = 1'b0;
        saw_we  = 1'b0;
        tick();
        if (we_o) saw_we = 1'b1;
        tick();
        if (we_o) saw_we = 1'b1;
        n_rst = 1'b1;
        tick();
        chk("midrst_ready_back", in_ready_o, 1'b1);
        for (int c = 0; c < 4; c++) begin
            if (we_o) saw_we = 1'b1;
            tick();
        end
        chk("midrst_no_we", saw_we, 1'b0);
        chk("midrst_instret_after", instret_o, 4'd0);

        exp_instret = 4'd0;
        setv(0, 2'd0, 3'b000, 2'd0, 5'd6, 1'b1, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 1'b0);
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
